// File: rtl/frame_tx_pkg.sv
// Shared types and constants for the frame transmit scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package frame_tx_pkg;

    localparam int PIX_W = 12;
    localparam logic [PIX_W-1:0] SYNC_WORD_DEF = 12'hFFF;

    typedef enum logic [2:0] {
        IDLE,
        HDR_SYNC,
        HDR_SEQ,
        FETCH,
        CAPTURE,
        SEND,
        DONE
    } state_e;

endpackage

// File: rtl/frame_tx_scheduler_if.sv
// Frame buffer read port plus pixel stream towards the serialiser.
// Latency: rd_data is valid one cycle after rd_en.
// Backpressure: pix_valid/pix_ready; a word moves on any edge where both are high.
// Signals: rd_en/rd_addr (read strobe, word address), rd_data (pixel read back),
//          pix_data/pix_valid (word offered), pix_ready (serialiser accepts).
interface frame_tx_scheduler_if #(
    parameter int ADDR_W = 17
) ();
    logic                           rd_en;
    logic [ADDR_W-1:0]              rd_addr;
    logic [frame_tx_pkg::PIX_W-1:0] rd_data;
    logic [frame_tx_pkg::PIX_W-1:0] pix_data;
    logic                           pix_valid;
    logic                           pix_ready;

    // master: the scheduler; slave: frame buffer + serialiser side
    modport master (
        output rd_en, rd_addr, pix_data, pix_valid,
        input  rd_data, pix_ready
    );
    modport slave (
        input  rd_en, rd_addr, pix_data, pix_valid,
        output rd_data, pix_ready
    );
endinterface

// File: rtl/frame_pos_counter.sv
// Column/row/address counters walking the active window in raster order.
// Latency: load/advance take effect on the next clk edge.
// Backpressure: none; advances only when told to.
// Ports: load_i clears all counters, advance_i steps one pixel, width_i/height_i
//        are the latched frame size, addr_o is the read address, last_pixel_o
//        flags the final pixel of the window.
module frame_pos_counter #(
    parameter int ADDR_W     = 17,
    parameter int MAX_W_BITS = 10,
    parameter int MAX_H_BITS = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic                  advance_i,
    input  logic [MAX_W_BITS-1:0] width_i,
    input  logic [MAX_H_BITS-1:0] height_i,
    output logic [ADDR_W-1:0]     addr_o,
    output logic                  last_pixel_o
);
    localparam logic [MAX_W_BITS-1:0] W_ONE = MAX_W_BITS'(1);
    localparam logic [MAX_H_BITS-1:0] H_ONE = MAX_H_BITS'(1);
    localparam logic [ADDR_W-1:0]     A_ONE = ADDR_W'(1);

    logic [MAX_W_BITS-1:0] col_q, col_d;
    logic [MAX_H_BITS-1:0] row_q, row_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  col_last;

    assign col_last     = (col_q == width_i - W_ONE);
    assign last_pixel_o = col_last && (row_q == height_i - H_ONE);
    assign addr_o       = addr_q;

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        addr_d = addr_q;
        if (load_i) begin
            col_d  = '0;
            row_d  = '0;
            addr_d = '0;
        end else if (advance_i) begin
            // Address is a free linear count, never rebuilt from row/col.
            addr_d = addr_q + A_ONE;
            if (col_last) begin
                col_d = '0;
                row_d = row_q + H_ONE;
            end else begin
                col_d = col_q + W_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            addr_q <= addr_d;
        end
    end
endmodule

// File: rtl/frame_tx_scheduler.sv
// Sends sync word, sequence number, then every window pixel of one frame.
// Latency: 3 cycles per pixel word (fetch, capture, send) plus stall cycles.
// Backpressure: a raised pix_valid holds word and valid until pix_ready, even on abort.
// Ports: start/abort control, cfg_width/cfg_height frame size (latched at start),
//        busy/frame_done status, bus = frame buffer read + pixel stream.
module frame_tx_scheduler
    import frame_tx_pkg::*;
#(
    parameter int               ADDR_W     = 17,
    parameter int               MAX_W_BITS = 10,
    parameter int               MAX_H_BITS = 9,
    parameter logic [PIX_W-1:0] SYNC_WORD  = SYNC_WORD_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [MAX_W_BITS-1:0] cfg_width,
    input  logic [MAX_H_BITS-1:0] cfg_height,
    output logic                  busy,
    output logic                  frame_done,
    frame_tx_scheduler_if.master  bus
);
    state_e                state_q, state_d;
    logic [MAX_W_BITS-1:0] width_q;
    logic [MAX_H_BITS-1:0] height_q;
    logic [PIX_W-1:0]      seq_q;
    logic [PIX_W-1:0]      pix_q;
    logic                  abort_pend_q, abort_pend_d;
    logic                  load, advance, last_pixel, xfer, abort_any;
    logic [ADDR_W-1:0]     addr;

    frame_pos_counter #(
        .ADDR_W    (ADDR_W),
        .MAX_W_BITS(MAX_W_BITS),
        .MAX_H_BITS(MAX_H_BITS)
    ) u_pos (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (load),
        .advance_i   (advance),
        .width_i     (width_q),
        .height_i    (height_q),
        .addr_o      (addr),
        .last_pixel_o(last_pixel)
    );

    // Outputs decode straight from state so reset clears them without a clock.
    assign bus.pix_valid = (state_q == HDR_SYNC) || (state_q == HDR_SEQ) || (state_q == SEND);
    assign bus.rd_en     = (state_q == FETCH);
    assign bus.rd_addr   = addr;
    assign busy          = (state_q != IDLE);
    assign frame_done    = (state_q == DONE);

    always_comb begin
        bus.pix_data = pix_q;
        if (state_q == HDR_SYNC)     bus.pix_data = SYNC_WORD;
        else if (state_q == HDR_SEQ) bus.pix_data = seq_q;
    end

    assign xfer      = bus.pix_valid && bus.pix_ready;
    // An abort seen while a word is held is remembered until that word leaves.
    assign abort_any = abort || abort_pend_q;

    always_comb begin
        state_d      = state_q;
        load         = 1'b0;
        advance      = 1'b0;
        abort_pend_d = abort_pend_q;
        if (state_q == IDLE)                          abort_pend_d = 1'b0;
        else if (bus.pix_valid && !xfer && abort)     abort_pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = HDR_SYNC;
                end
            end
            HDR_SYNC: begin
                if (xfer) state_d = abort_any ? IDLE : HDR_SEQ;
            end
            HDR_SEQ: begin
                if (xfer) begin
                    if (abort_any)                           state_d = IDLE;
                    else if (width_q == '0 || height_q == '0) state_d = DONE;
                    else                                     state_d = FETCH;
                end
            end
            FETCH:   state_d = abort ? IDLE : CAPTURE;
            CAPTURE: state_d = abort ? IDLE : SEND;
            SEND: begin
                if (xfer) begin
                    advance = 1'b1;
                    if (abort_any)       state_d = IDLE;
                    else if (last_pixel) state_d = DONE;
                    else                 state_d = FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            seq_q        <= '0;
            pix_q        <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            abort_pend_q <= abort_pend_d;
            if (state_q == IDLE && start) begin
                width_q  <= cfg_width;
                height_q <= cfg_height;
            end
            if (state_q == CAPTURE) pix_q <= bus.rd_data;
            // 12-bit counter wraps 4095 -> 0 on its own.
            if (state_q == DONE)    seq_q <= seq_q + PIX_W'(1);
        end
    end
endmodule
